// File: rtl/moore_pattern_tx.sv
// -----------------------------------------------------------------------------
// moore_pattern_tx
//
// Serial bit-pattern transmitter that feeds the single-bit input of a Moore
// sequence detector. On an accepted start it shifts out a latched pattern,
// MSB first, one bit per clock. The pattern repeats num_reps times (0 is
// treated as 1), with `gap` idle cycles between repetitions.
//
// Ports:
//   clk        in   system clock, rising edge
//   n_rst      in   asynchronous active-low reset
//   start      in   request a transmission (sampled only when not busy)
//   abort      in   synchronous cancel; wins over start
//   pattern    in   [PAT_WIDTH] bits to send, MSB first, latched on start
//   num_reps   in   [REP_WIDTH] repetitions, latched on start, 0 -> 1
//   gap        in   [GAP_WIDTH] idle cycles between repetitions, latched
//   idle_val   in   level driven on o when no pattern bit is sent (not latched)
//   o          out  registered serial output
//   tx_active  out  o currently carries a pattern bit
//   busy       out  high from the first through the last pattern bit
//   done       out  one-cycle pulse in the cycle after the final bit
//   state_dbg  out  [2] current FSM state (0 IDLE, 1 SEND, 2 GAP)
//
// Handshake: a request is `start` high at a rising edge while the block is
// not busy (IDLE, including the `done` cycle) and `abort` is low. There is no
// back-pressure; busy=1 means further start pulses are dropped, and done
// marks completion of a transmission that was not aborted.
// -----------------------------------------------------------------------------
module moore_pattern_tx #(
    parameter int PAT_WIDTH = 4,
    parameter int REP_WIDTH = 4,
    parameter int GAP_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [PAT_WIDTH-1:0] pattern,
    input  logic [REP_WIDTH-1:0] num_reps,
    input  logic [GAP_WIDTH-1:0] gap,
    input  logic                 idle_val,
    output logic                 o,
    output logic                 tx_active,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           state_dbg
);

    localparam int IDX_W = (PAT_WIDTH > 1) ? $clog2(PAT_WIDTH) : 1;
    localparam logic [IDX_W-1:0]     IDX_MSB = IDX_W'(PAT_WIDTH - 1);
    localparam logic [REP_WIDTH-1:0] REP_ONE = REP_WIDTH'(1);
    localparam logic [GAP_WIDTH-1:0] GAP_ONE = GAP_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // State reflects what the registered outputs show in the current cycle:
    // SEND means o holds pattern bit bit_idx_q, GAP means an idle gap cycle.
    state_t               state_q,   state_d;
    logic [PAT_WIDTH-1:0] pat_q,     pat_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    // Repetitions still to be sent, counting the one in progress.
    logic [REP_WIDTH-1:0] reps_q,    reps_d;
    // Latched gap length and the remaining gap cycles including the current one.
    logic [GAP_WIDTH-1:0] gap_len_q, gap_len_d;
    logic [GAP_WIDTH-1:0] gap_cnt_q, gap_cnt_d;

    logic o_q,         o_d;
    logic tx_active_q, tx_active_d;
    logic busy_q,      busy_d;
    logic done_q,      done_d;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            pat_q       <= '0;
            bit_idx_q   <= '0;
            reps_q      <= '0;
            gap_len_q   <= '0;
            gap_cnt_q   <= '0;
            o_q         <= 1'b0;
            tx_active_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            bit_idx_q   <= bit_idx_d;
            reps_q      <= reps_d;
            gap_len_q   <= gap_len_d;
            gap_cnt_q   <= gap_cnt_d;
            o_q         <= o_d;
            tx_active_q <= tx_active_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        bit_idx_d = bit_idx_q;
        reps_d    = reps_q;
        gap_len_d = gap_len_q;
        gap_cnt_d = gap_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d   = ST_SEND;
                    pat_d     = pattern;
                    bit_idx_d = IDX_MSB;
                    reps_d    = (num_reps == '0) ? REP_ONE : num_reps;
                    gap_len_d = gap;
                    gap_cnt_d = '0;
                end
            end

            ST_SEND: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (bit_idx_q != '0) begin
                    bit_idx_d = bit_idx_q - 1'b1;
                end else if (reps_q > REP_ONE) begin
                    // LSB shown now and more repetitions follow.
                    reps_d = reps_q - 1'b1;
                    if (gap_len_q != '0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = gap_len_q;
                    end else begin
                        bit_idx_d = IDX_MSB;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_GAP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (gap_cnt_q > GAP_ONE) begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end else begin
                    state_d   = ST_SEND;
                    gap_cnt_d = '0;
                    bit_idx_d = IDX_MSB;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic: registered outputs are computed from the next state so
    // that they line up with the cycle the state describes.
    // -------------------------------------------------------------------------
    always_comb begin
        o_d         = idle_val;
        tx_active_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        if (state_d == ST_SEND) begin
            o_d         = pat_d[bit_idx_d];
            tx_active_d = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);

        // Leaving SEND for IDLE without abort only happens after the last bit.
        done_d = (state_q == ST_SEND) && (state_d == ST_IDLE) && !abort;
    end

    assign o         = o_q;
    assign tx_active = tx_active_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule
